instruction_sequencer: RTL

Instruction-issuing end of the core's start/busy handshake. Holds a small loadable program memory and steps a program counter. Issues each instruction to the core by driving the instruction word and a one-cycle start pulse, then waits for the core's busy to rise and fall before issuing the next. Sits between the testbench/host loader and core; its instructionOut, start and coreBusy ports connect directly to the core's instructionIn, start and busy ports.

---
 rtl/instruction_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: loadable program memory plus a program counter that
// issues instructions to a core over a start/busy handshake. Each instruction
// is presented with a one-cycle start pulse; the sequencer then waits for the
// core's busy to rise (bounded by an acknowledge timeout) and fall again
// before issuing the next one.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module instruction_sequencer #(
   parameter int INSTR_WIDTH = `INSTRUCTION_WIDTH,
   parameter int DEPTH       = 16,
   parameter int ADDR_WIDTH  = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_we,
   input  logic [ADDR_WIDTH-1:0]  load_addr,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   run,
   input  logic [ADDR_WIDTH:0]    run_length,
   input  logic                   abort,
   input  logic                   coreBusy,
   output logic [INSTR_WIDTH-1:0] instructionOut,
   output logic                   start,
   output logic                   running,
   output logic                   done,
   output logic                   timeoutError,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [ADDR_WIDTH:0]    issuedCount
);

   localparam int CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0]  ACK_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_ACK   = 3'd2,
      S_EXEC  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                 state, state_next;
   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]    length, length_next;
   logic [ADDR_WIDTH-1:0]  pc_next;
   logic [ADDR_WIDTH:0]    issued_next;
   logic [CNT_WIDTH-1:0]   ack_cnt, ack_cnt_next;
   logic                   abort_pend, abort_pend_next;
   logic                   timeout_next;

   // Program memory write port; the program can only change while idle.
   always_ff @(posedge clk) begin
      if (load_we && (state == S_IDLE)) begin
         mem[load_addr] <= load_data;
      end
   end

   // Next-state, counter and flag computation for the issue handshake.
   always_comb begin
      state_next      = state;
      length_next     = length;
      pc_next         = pc;
      issued_next     = issuedCount;
      ack_cnt_next    = ack_cnt;
      timeout_next    = timeoutError;
      abort_pend_next = abort_pend | abort;
      case (state)
         S_IDLE: begin
            abort_pend_next = 1'b0;
            if (run) begin
               length_next  = (run_length > DEPTH_LEN) ? DEPTH_LEN : run_length;
               pc_next      = '0;
               issued_next  = '0;
               timeout_next = 1'b0;
               if (run_length == '0) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_ISSUE;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_ISSUE: begin
            ack_cnt_next = '0;
            state_next   = S_ACK;
         end
         S_ACK: begin
            if (coreBusy) begin
               state_next = S_EXEC;
            end else if (ack_cnt == ACK_LAST) begin
               timeout_next = 1'b1;
               state_next   = S_DONE;
            end else begin
               ack_cnt_next = ack_cnt + CNT_WIDTH'(1);
            end
         end
         S_EXEC: begin
            if (!coreBusy) begin
               issued_next = issuedCount + (ADDR_WIDTH + 1)'(1);
               pc_next     = pc + ADDR_WIDTH'(1);
               // An abort raised in this very cycle counts as already seen.
               if ((issued_next == length) || abort_pend || abort) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_ISSUE;
               end
            end else begin
               state_next = S_EXEC;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register and registered outputs, derived from the next state so
   // start/running/done line up exactly with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         length         <= '0;
         pc             <= '0;
         issuedCount    <= '0;
         ack_cnt        <= '0;
         abort_pend     <= 1'b0;
         timeoutError   <= 1'b0;
         start          <= 1'b0;
         running        <= 1'b0;
         done           <= 1'b0;
         instructionOut <= '0;
      end else begin
         state        <= state_next;
         length       <= length_next;
         pc           <= pc_next;
         issuedCount  <= issued_next;
         ack_cnt      <= ack_cnt_next;
         abort_pend   <= abort_pend_next;
         timeoutError <= timeout_next;
         start        <= (state_next == S_ISSUE);
         running      <= (state_next != S_IDLE);
         done         <= (state_next == S_DONE);
         if (state_next == S_ISSUE) begin
            instructionOut <= mem[pc_next];
         end else begin
            instructionOut <= instructionOut;
         end
      end
   end

endmodule
